// File: rtl/dma_mem_responder.sv
// dma_mem_responder: arbitrates a single-port word RAM between the DMA engine
// and the CPU. Ownership is round-robin, and a burst cap bounds how long one
// side can hold the RAM while the other side waits.
//
// state   | meaning
// --------+---------------------------------------------------------
// IDLE    | no owner; picks the next owner from the request lines
// OWN_DMA | DMA port granted; its strobes reach the RAM
// OWN_CPU | CPU port granted; its strobes reach the RAM
// HANDOFF | one dead cycle with no grant before the waiting side owns
module dma_mem_responder #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 8,
  parameter int MAX_BURST  = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  dma_request,
  output logic                  dma_grant,
  input  logic [31:0]           dma_addr,
  input  logic [DATA_WIDTH-1:0] dma_wdata,
  output logic [DATA_WIDTH-1:0] dma_rdata,
  input  logic                  dma_wr_enable,
  input  logic                  dma_rd_enable,
  input  logic                  cpu_request,
  output logic                  cpu_grant,
  input  logic [31:0]           cpu_addr,
  input  logic [DATA_WIDTH-1:0] cpu_wdata,
  output logic [DATA_WIDTH-1:0] cpu_rdata,
  input  logic                  cpu_wr_enable,
  input  logic                  cpu_rd_enable,
  output logic                  err
);

  localparam int DEPTH = 2 ** ADDR_WIDTH;
  localparam int BW    = $clog2(MAX_BURST + 1);
  localparam logic [BW-1:0] MAX_CNT = BW'(MAX_BURST);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    OWN_DMA = 2'd1,
    OWN_CPU = 2'd2,
    HANDOFF = 2'd3
  } state_t;

  state_t                state_q, state_d;
  logic                  last_dma_q, last_dma_d;   // 1: DMA owned last, 0: CPU
  logic [BW-1:0]         burst_q, burst_d;
  logic [DATA_WIDTH-1:0] dma_rdata_q, dma_rdata_d;
  logic [DATA_WIDTH-1:0] cpu_rdata_q, cpu_rdata_d;
  logic                  err_q, err_d;

  logic [DATA_WIDTH-1:0] mem_q [DEPTH];

  logic                  own_dma, own_cpu;
  logic                  sel_wr, sel_rd, other_req;
  logic [31:0]           sel_addr;
  logic [DATA_WIDTH-1:0] sel_wdata;
  logic [ADDR_WIDTH-1:0] idx;
  logic                  cap_hit, acc, oor, collide, do_write, do_read;
  logic [DATA_WIDTH-1:0] rd_val;

  // Route the owning port onto the RAM and classify its access.
  // Once the cap is reached with the other side waiting, the owner's
  // strobes are held off until the grant drops on the following edge.
  always_comb begin
    own_dma   = (state_q == OWN_DMA);
    own_cpu   = (state_q == OWN_CPU);
    sel_wr    = own_dma ? dma_wr_enable : cpu_wr_enable;
    sel_rd    = own_dma ? dma_rd_enable : cpu_rd_enable;
    sel_addr  = own_dma ? dma_addr      : cpu_addr;
    sel_wdata = own_dma ? dma_wdata     : cpu_wdata;
    other_req = own_dma ? cpu_request   : dma_request;
    idx       = sel_addr[ADDR_WIDTH-1:0];
    cap_hit   = (burst_q == MAX_CNT) && other_req;
    acc       = (own_dma || own_cpu) && (sel_wr || sel_rd) && !cap_hit;
    oor       = |sel_addr[31:ADDR_WIDTH];
    collide   = sel_wr && sel_rd;
    do_write  = acc && sel_wr && !oor;
    do_read   = acc && sel_rd && !sel_wr;
    rd_val    = oor ? '0 : mem_q[idx];
  end

  // Ownership next-state logic and last-owner pointer.
  always_comb begin
    state_d    = state_q;
    last_dma_d = last_dma_q;
    case (state_q)
      IDLE: begin
        if (dma_request && cpu_request) state_d = last_dma_q ? OWN_CPU : OWN_DMA;
        else if (dma_request)           state_d = OWN_DMA;
        else if (cpu_request)           state_d = OWN_CPU;
      end
      OWN_DMA: begin
        if (!dma_request)                             state_d = IDLE;
        else if ((burst_q == MAX_CNT) && cpu_request) state_d = HANDOFF;
      end
      OWN_CPU: begin
        if (!cpu_request)                             state_d = IDLE;
        else if ((burst_q == MAX_CNT) && dma_request) state_d = HANDOFF;
      end
      HANDOFF: state_d = last_dma_q ? OWN_CPU : OWN_DMA;
      default: state_d = IDLE;
    endcase
    if (state_d == OWN_DMA)      last_dma_d = 1'b1;
    else if (state_d == OWN_CPU) last_dma_d = 1'b0;
  end

  // Burst counter, per-port read data holding registers and error pulse.
  always_comb begin
    burst_d     = burst_q;
    dma_rdata_d = dma_rdata_q;
    cpu_rdata_d = cpu_rdata_q;
    err_d       = acc && (oor || collide);
    if (!own_dma && !own_cpu)                burst_d = '0;
    else if (acc && (burst_q != MAX_CNT))    burst_d = burst_q + 1'b1;
    if (do_read) begin
      if (own_dma) dma_rdata_d = rd_val;
      else         cpu_rdata_d = rd_val;
    end
  end

  // Control and output registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q     <= IDLE;
      last_dma_q  <= 1'b0;
      burst_q     <= '0;
      dma_rdata_q <= '0;
      cpu_rdata_q <= '0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      last_dma_q  <= last_dma_d;
      burst_q     <= burst_d;
      dma_rdata_q <= dma_rdata_d;
      cpu_rdata_q <= cpu_rdata_d;
      err_q       <= err_d;
    end
  end

  // Word RAM; contents survive reset, but no write lands on a reset edge.
  always_ff @(posedge clk) begin
    if (reset && do_write) mem_q[idx] <= sel_wdata;
  end

  assign dma_grant = own_dma;
  assign cpu_grant = own_cpu;
  assign dma_rdata = dma_rdata_q;
  assign cpu_rdata = cpu_rdata_q;
  assign err       = err_q;

endmodule

// File: doc/dma_mem_responder.md
# dma_mem_responder

Memory-side responder for the DMA controller's request/grant memory port. It arbitrates between the DMA engine and the CPU and serves both from an internal single-port word RAM. Grants are registered and round-robin between the two requesters. A burst cap prevents either requester from starving the other. Sits between the DMA controller, the CPU bus and on-chip storage.

## Interface
- DATA_WIDTH, 32, word width
- ADDR_WIDTH, 8, RAM index width; DEPTH = 2**ADDR_WIDTH words
- MAX_BURST, 16, accesses allowed per grant while the other requester waits (≥1)

Ports:
- clk  in  1  single clock, all logic on posedge
- reset  in  1  synchronous, active-low
- dma_request  in  1  DMA requests ownership
- dma_grant  out  1  DMA owns the RAM
- dma_addr  in  32  word address
- dma_wdata  in  DATA_WIDTH  write data
- dma_rdata  out  DATA_WIDTH  read data
- dma_wr_enable  in  1  write strobe
- dma_rd_enable  in  1  read strobe
- cpu_request, cpu_grant, cpu_addr, cpu_wdata, cpu_rdata, cpu_wr_enable, cpu_rd_enable: same widths and meanings as the DMA port
- err  out  1  one-cycle pulse on an illegal access

## Operation
- FSM states: IDLE, OWN_DMA, OWN_CPU, HANDOFF.
- IDLE:
  - Only one requester high → go to that requester's OWN state.
  - Both high → grant the requester that was not the last owner. The last-owner pointer resets to CPU, so the DMA wins the first tie.
- OWN_x:
  - x_grant = 1.
  - Drop of x_request → IDLE.
  - burst_cnt reaches MAX_BURST while the other request is high → HANDOFF.
- HANDOFF: one cycle with no grant, then the other requester's OWN state. burst_cnt clears on every OWN entry.
- Access: valid only while the port's grant is 1 and an enable is high. Strobes from an ungranted port are ignored. They do not assert err.
- Each valid access increments burst_cnt. burst_cnt saturates at MAX_BURST.
- Address check: index = addr[ADDR_WIDTH-1:0]. If addr[31:ADDR_WIDTH] ≠ 0:
  - The access is dropped: no write, rdata forced to 0 next cycle.
  - err pulses.
  - The access still counts toward the burst.
- Write: RAM[index] ← wdata at the same posedge the strobe is sampled.
- Read: RAM[index] appears on the granted port's rdata the next cycle. rdata holds until the next valid read on that port.
- wr_enable and rd_enable both high: the write is performed, the read is ignored, err pulses.
- Read after write to the same index on consecutive cycles returns the new data. The RAM is write-first.
- Reset:
  - Outputs: grants 0, both rdata 0, err 0.
  - State: FSM IDLE, burst_cnt 0, pointer CPU.
  - RAM contents are not reset.
- Reset asserted mid-burst:
  - Grant drops on the next posedge.
  - An in-flight read's data is discarded; rdata = 0.

## Timing
- Grant latency: request high at edge N → grant high after edge N+1 (registered). Idle release: request low at edge N → grant low after edge N+1.
- Back-to-back: grant may drop and the other grant rise on consecutive cycles only through IDLE or HANDOFF. Never both grants high.
- Handoff timing: the MAX_BURST-th valid access is at edge N.
  - The owner's grant is low after N+1.
  - The other grant is high after N+2.
  - Strobes from the old owner after its grant falls are ignored.
- Read latency: exactly 1 cycle.
- Write latency: 0; data is visible to a read issued on the next cycle.
- Throughput: 1 access per cycle for the owner.
- err: high for exactly the cycle after the offending edge.

## Test plan
- Reset: hold reset=0 for 3 cycles with both requests high → grants, rdata, err all 0. After release, dma_grant=1 at the second edge and cpu_grant=0.
- DMA write/read: DMA writes 0xA5A5_0001..0xA5A5_0004 to addr 0..3, then reads 0..3 → dma_rdata returns the same words, each 1 cycle after its strobe. err stays 0.
- Round-robin and cap: both requests held high, DMA issuing continuous reads, MAX_BURST=16 → DMA gets exactly 16 accesses. One HANDOFF cycle with no grant follows, then cpu_grant=1 and CPU gets 16 accesses.
- Out of range: CPU reads addr 0x100 (ADDR_WIDTH=8) after RAM[0]=0xDEAD_BEEF → cpu_rdata=0 and err=1 for one cycle. A write to 0x100 leaves RAM[0] equal to 0xDEAD_BEEF.
- Collisions: wr+rd both high on the DMA port at addr 5 with wdata 0x1234 → RAM[5]=0x1234, err pulses, dma_rdata unchanged. Ungranted CPU write to addr 5 → RAM[5] stays 0x1234, no err.
- Mid-burst reset: reset=0 during an OWN_DMA read → dma_grant=0 and dma_rdata=0 after the next edge. After release with only cpu_request high → cpu_grant after 1 cycle.
